// File: rtl/p3_shifter.sv
// P3 datapath single-position shifter: pass, LSL, LSR, ASR by one bit, with carry/zero/neg flags.
// Optional build macro P3_SHIFTER_BYPASS_EN makes the outputs combinational (zero latency).
module p3_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  output logic        out_valid,
  output logic [15:0] sout,
  output logic        cout,
  output logic        zero,
  output logic        neg
);

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_LSL  = 2'b01,
    OP_LSR  = 2'b10,
    OP_ASR  = 2'b11
  } shift_op_t;

  shift_op_t   op;
  logic [15:0] res;
  logic        res_c;

  assign op = shift_op_t'(shift);

  always_comb begin
    res   = in;
    res_c = 1'b0;
    unique case (op)
      OP_PASS: begin
        res   = in;
        res_c = 1'b0;
      end
      OP_LSL: begin
        res   = {in[14:0], 1'b0};
        res_c = in[15];
      end
      OP_LSR: begin
        res   = {1'b0, in[15:1]};
        res_c = in[0];
      end
      OP_ASR: begin
        res   = {in[15], in[15:1]};
        res_c = in[0];
      end
      default: begin
        res   = in;
        res_c = 1'b0;
      end
    endcase
  end

`ifdef P3_SHIFTER_BYPASS_EN
  assign out_valid = in_valid;
  assign sout      = res;
  assign cout      = res_c;
`else
  logic        valid_q;
  logic [15:0] sout_q;
  logic        cout_q;

  // Result registers hold their value when no operand is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      sout_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sout_q <= res;
        cout_q <= res_c;
      end
    end
  end

  assign out_valid = valid_q;
  assign sout      = sout_q;
  assign cout      = cout_q;
`endif

  // Flags follow whatever sout currently shows, so reset naturally yields zero=1.
  assign zero = (sout == '0);
  assign neg  = sout[15];

endmodule

// File: tb/tb_p3_shifter.sv
// Self-checking bench for p3_shifter: directed boundary cases followed by randomized traffic
// compared against an arithmetic reference model.
module tb_p3_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in;
  logic [1:0]  shift;
  logic        out_valid;
  logic [15:0] sout;
  logic        cout;
  logic        zero;
  logic        neg;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state: what the outputs should show.
  logic        exp_v    = 1'b0;
  logic [15:0] exp_sout = 16'h0000;
  logic        exp_c    = 1'b0;

  p3_shifter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in),
    .shift     (shift),
    .out_valid (out_valid),
    .sout      (sout),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Shift rules written as plain integer arithmetic; returns {cout, result}.
  function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [1:0] op);
    int unsigned v = a;
    int unsigned r;
    int unsigned c;
    case (op)
      2'd0: begin r = v; c = 0; end
      2'd1: begin r = (v * 2) % 65536; c = v / 32768; end
      2'd2: begin r = v / 2; c = v % 2; end
      default: begin r = v / 2 + ((v >= 32768) ? 32768 : 0); c = v % 2; end
    endcase
    return {c[0], r[15:0]};
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {15'd0, out_valid}, {15'd0, exp_v});
    check({tag, ".sout"},  sout, exp_sout);
    check({tag, ".cout"},  {15'd0, cout}, {15'd0, exp_c});
    check({tag, ".zero"},  {15'd0, zero}, {15'd0, (exp_sout == 16'h0000)});
    check({tag, ".neg"},   {15'd0, neg},  {15'd0, exp_sout[15]});
  endtask

  // Applies the given inputs across one clock edge, advances the model and checks.
  task automatic cycle(input logic r, input logic v, input logic [15:0] d, input logic [1:0] s,
                       input string tag);
    logic [16:0] m;
    reset = r; in_valid = v; in = d; shift = s;
    m = ref_op(d, s);
`ifdef P3_SHIFTER_BYPASS_EN
    #1;
    exp_v = v;
    exp_sout = m[15:0];
    exp_c = m[16];
    check_all(tag);
    @(posedge clk);
    #1;
`else
    @(posedge clk);
    #1;
    if (r) begin
      exp_v = 1'b0; exp_sout = 16'h0000; exp_c = 1'b0;
    end else if (v) begin
      exp_v = 1'b1; exp_sout = m[15:0]; exp_c = m[16];
    end else begin
      exp_v = 1'b0;
    end
    check_all(tag);
`endif
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in = '0; shift = '0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 16'h0000, 2'b00, "reset");
    cycle(1'b1, 1'b0, 16'h0000, 2'b00, "reset2");

    cycle(1'b0, 1'b1, 16'h1234, 2'b00, "pass");
    cycle(1'b0, 1'b1, 16'h1234, 2'b01, "lsl");
    cycle(1'b0, 1'b1, 16'h8000, 2'b01, "lsl_8000");
    cycle(1'b0, 1'b1, 16'h1234, 2'b10, "lsr");
    cycle(1'b0, 1'b1, 16'h0001, 2'b10, "lsr_0001");
    cycle(1'b0, 1'b1, 16'hF234, 2'b11, "asr_neg");
    cycle(1'b0, 1'b1, 16'hFFFF, 2'b11, "asr_ffff");
    cycle(1'b0, 1'b1, 16'h8001, 2'b00, "pass_neg");
    cycle(1'b0, 1'b0, 16'h5555, 2'b01, "idle1");
    cycle(1'b0, 1'b0, 16'h0000, 2'b10, "idle2");
    cycle(1'b0, 1'b0, 16'hAAAA, 2'b11, "idle3");
    cycle(1'b1, 1'b1, 16'h4321, 2'b01, "reset_drop");
    cycle(1'b0, 1'b0, 16'h4321, 2'b01, "after_reset");
    cycle(1'b0, 1'b1, 16'h7FFF, 2'b01, "lsl_7fff");

    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        v;
      logic [15:0] d;
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: d = 16'h8000;
        1: d = 16'h0001;
        2: d = 16'hFFFF;
        3: d = 16'h0000;
        default: d = 16'($urandom);
      endcase
      cycle(r, v, d, 2'($urandom_range(0, 3)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
